// File: rtl/alu_collector_pkg.sv
// Shared types and constants for the ALU operand collector.
// Command codes, operand-requirement encoding and timeout length.
package alu_collector_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    A_ONLY,
    B_ONLY,
    BOTH
  } req_e;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // MODE=1 arithmetic command codes
  localparam int unsigned M1_ADD     = 0;
  localparam int unsigned M1_SUB     = 1;
  localparam int unsigned M1_ADD_CIN = 2;
  localparam int unsigned M1_SUB_CIN = 3;
  localparam int unsigned M1_INC_A   = 4;
  localparam int unsigned M1_DEC_A   = 5;
  localparam int unsigned M1_INC_B   = 6;
  localparam int unsigned M1_DEC_B   = 7;
  localparam int unsigned M1_CMP     = 8;
  localparam int unsigned M1_MUL_INC = 9;
  localparam int unsigned M1_MUL_SHL = 10;

  // MODE=0 logic command codes
  localparam int unsigned M0_AND    = 0;
  localparam int unsigned M0_NAND   = 1;
  localparam int unsigned M0_OR     = 2;
  localparam int unsigned M0_NOR    = 3;
  localparam int unsigned M0_XOR    = 4;
  localparam int unsigned M0_XNOR   = 5;
  localparam int unsigned M0_NOT_A  = 6;
  localparam int unsigned M0_NOT_B  = 7;
  localparam int unsigned M0_SHR1_A = 8;
  localparam int unsigned M0_SHL1_A = 9;
  localparam int unsigned M0_SHR1_B = 10;
  localparam int unsigned M0_SHL1_B = 11;
  localparam int unsigned M0_ROL    = 12;
  localparam int unsigned M0_ROR    = 13;

  function automatic logic [1:0] req_mask(req_e r);
    logic [1:0] m;
    m = 2'b00;
    unique case (r)
      A_ONLY:  m = 2'b01;
      B_ONLY:  m = 2'b10;
      BOTH:    m = 2'b11;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

  function automatic logic req_met(req_e r, logic a, logic b);
    return (r != NONE) && ((req_mask(r) & ~{b, a}) == 2'b00);
  endfunction

endpackage

// File: rtl/alu_operand_decode.sv
// Maps MODE/CMD to the operand set the ALU needs.
// Codes outside both command tables flag illegal.
import alu_collector_pkg::*;

module alu_operand_decode #(
  parameter int CMD_WIDTH = 4
) (
  input  logic                 mode,
  input  logic [CMD_WIDTH-1:0] cmd,
  output req_e                 req,
  output logic                 illegal
);

  logic [31:0] c;

  assign c = 32'(cmd);

  always_comb begin
    req = NONE;
    if (mode) begin
      unique case (1'b1)
        c inside {M1_ADD, M1_SUB, M1_ADD_CIN,
                  M1_SUB_CIN, M1_CMP, M1_MUL_INC,
                  M1_MUL_SHL}:
          req = BOTH;
        c inside {M1_INC_A, M1_DEC_A}:
          req = A_ONLY;
        c inside {M1_INC_B, M1_DEC_B}:
          req = B_ONLY;
        default:
          req = NONE;
      endcase
    end else begin
      unique case (1'b1)
        c inside {M0_AND, M0_NAND, M0_OR, M0_NOR,
                  M0_XOR, M0_XNOR, M0_ROL, M0_ROR}:
          req = BOTH;
        c inside {M0_NOT_A, M0_SHR1_A, M0_SHL1_A}:
          req = A_ONLY;
        c inside {M0_NOT_B, M0_SHR1_B, M0_SHL1_B}:
          req = B_ONLY;
        default:
          req = NONE;
      endcase
    end
  end

  assign illegal = (req == NONE);

endmodule

// File: rtl/alu_operand_collector.sv
// Collects ALU operands across cycles, issues one registered request.
// Define ALU_COLLECTOR_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
import alu_collector_pkg::*;

module alu_operand_collector #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CE_in,
  input  logic                 MODE_in,
  input  logic                 CIN_in,
  input  logic [CMD_WIDTH-1:0] CMD_in,
  input  logic [1:0]           INP_VALID_in,
  input  logic [WIDTH-1:0]     OPA_in,
  input  logic [WIDTH-1:0]     OPB_in,
  output logic                 in_ready,
  output logic                 CE,
  output logic                 MODE,
  output logic                 CIN,
  output logic [CMD_WIDTH-1:0] CMD,
  output logic [1:0]           INP_VALID,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 cmd_err
);

  state_e state, state_nxt;

  logic                 mode_q, cin_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  req_e                 req_q;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic                 have_a, have_b;

  req_e dec_req;
  logic dec_ill;

  logic                 in_wait, acc, rej;
  logic                 take_a, take_b;
  logic                 nxt_a, nxt_b;
  logic [WIDTH-1:0]     nxt_opa, nxt_opb;
  req_e                 cur_req;
  logic [1:0]           cur_mask;
  logic                 cur_mode, cur_cin;
  logic [CMD_WIDTH-1:0] cur_cmd;
  logic                 done, to_hit;

`ifdef ALU_COLLECTOR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
`endif

  alu_operand_decode #(
    .CMD_WIDTH(CMD_WIDTH)
  ) u_decode (
    .mode   (MODE_in),
    .cmd    (CMD_in),
    .req    (dec_req),
    .illegal(dec_ill)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    in_wait   = (state == S_WAIT);
    acc       = (state == S_IDLE) & CE_in & ~dec_ill;
    rej       = (state == S_IDLE) & CE_in & dec_ill;
    take_a    = (acc | (in_wait & CE_in)) & INP_VALID_in[0];
    take_b    = (acc | (in_wait & CE_in)) & INP_VALID_in[1];
    // A fresh request forgets whatever the previous one held
    nxt_a     = take_a | (in_wait & have_a);
    nxt_b     = take_b | (in_wait & have_b);
    nxt_opa   = take_a ? OPA_in : opa_q;
    nxt_opb   = take_b ? OPB_in : opb_q;
    cur_req   = acc ? dec_req : req_q;
    cur_mode  = acc ? MODE_in : mode_q;
    cur_cin   = acc ? CIN_in  : cin_q;
    cur_cmd   = acc ? CMD_in  : cmd_q;
    cur_mask  = req_mask(cur_req);
    done      = (acc | in_wait) & req_met(cur_req, nxt_a, nxt_b);
`ifdef ALU_COLLECTOR_TIMEOUT_EN
    to_hit    = in_wait & ~done &
                (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    to_hit    = 1'b0;
`endif
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (done)     state_nxt = S_ISSUE;
        else if (acc) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done)        state_nxt = S_ISSUE;
        else if (to_hit) state_nxt = S_IDLE;
      end
      S_ISSUE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= 1'b0;
      cin_q     <= 1'b0;
      cmd_q     <= '0;
      req_q     <= NONE;
      opa_q     <= '0;
      opb_q     <= '0;
      have_a    <= 1'b0;
      have_b    <= 1'b0;
      CE        <= 1'b0;
      MODE      <= 1'b0;
      CIN       <= 1'b0;
      CMD       <= '0;
      INP_VALID <= 2'b00;
      OPA       <= '0;
      OPB       <= '0;
      cmd_err   <= 1'b0;
    end else begin
      CE      <= done;
      cmd_err <= rej;
      opa_q   <= nxt_opa;
      opb_q   <= nxt_opb;
      have_a  <= nxt_a & ~done & ~to_hit;
      have_b  <= nxt_b & ~done & ~to_hit;
      if (acc) begin
        mode_q <= MODE_in;
        cin_q  <= CIN_in;
        cmd_q  <= CMD_in;
        req_q  <= dec_req;
      end
      if (done) begin
        MODE      <= cur_mode;
        CIN       <= cur_cin;
        CMD       <= cur_cmd;
        INP_VALID <= cur_mask;
        OPA       <= cur_mask[0] ? nxt_opa : '0;
        OPB       <= cur_mask[1] ? nxt_opb : '0;
      end
    end
  end

`ifdef ALU_COLLECTOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (in_wait && state_nxt == S_WAIT) cnt <= cnt + 1'b1;
      else                                cnt <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready = (state != S_ISSUE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_alu_operand_collector.sv
// Self-checking bench for alu_operand_collector.
// Directed scenarios plus random traffic against a request-level model.
module tb_alu_operand_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce_in, mode_in, cin_in;
  logic [3:0] cmd_in;
  logic [1:0] iv_in;
  logic [7:0] opa_in, opb_in;
  logic       in_ready, CE, MODE, CIN;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [7:0] OPA, OPB;
  logic       busy, timeout_err, cmd_err;

  int errors = 0;
  int checks = 0;

  bit       m_pend, m_iss, m_mode, m_cin;
  bit [1:0] m_need, m_have;
  bit [3:0] m_cmd;
  bit [7:0] m_opa, m_opb;
  int       m_wait;

  bit       e_ce, e_mode, e_cin, e_busy, e_rdy, e_to, e_cerr;
  bit [3:0] e_cmd;
  bit [1:0] e_iv;
  bit [7:0] e_opa, e_opb;

  always #5 clk = ~clk;

  alu_operand_collector #(.WIDTH(8), .CMD_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .CE_in(ce_in), .MODE_in(mode_in), .CIN_in(cin_in),
    .CMD_in(cmd_in), .INP_VALID_in(iv_in),
    .OPA_in(opa_in), .OPB_in(opb_in),
    .in_ready(in_ready), .CE(CE), .MODE(MODE), .CIN(CIN),
    .CMD(CMD), .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB),
    .busy(busy), .timeout_err(timeout_err), .cmd_err(cmd_err)
  );

  // {illegal, needs_b, needs_a}
  function automatic bit [2:0] need_of(bit md, int c);
    if (md) begin
      if (c inside {[0:3], [8:10]}) return 3'b011;
      if (c inside {4, 5})          return 3'b001;
      if (c inside {6, 7})          return 3'b010;
    end else begin
      if (c inside {[0:5], 12, 13}) return 3'b011;
      if (c inside {6, 8, 9})       return 3'b001;
      if (c inside {7, 10, 11})     return 3'b010;
    end
    return 3'b100;
  endfunction

  task automatic drive(bit ce, bit md, bit ci, bit [3:0] c,
                       bit [1:0] v, bit [7:0] a, bit [7:0] b);
    ce_in = ce; mode_in = md; cin_in = ci; cmd_in = c;
    iv_in = v; opa_in = a; opb_in = b;
  endtask

  task automatic set_idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 8'h00, 8'h00);
  endtask

  // Advance the model over one clock edge, then settle past the edge
  task automatic step();
    bit [2:0] d;
    bit fire;
    fire = 0; e_ce = 0; e_to = 0; e_cerr = 0;
    if (!rst) begin
      m_pend = 0; m_iss = 0; m_have = 0; m_opa = 0; m_opb = 0;
      e_mode = 0; e_cin = 0; e_cmd = 0; e_iv = 0;
      e_opa = 0; e_opb = 0;
    end else if (m_iss) begin
      m_iss = 0;
    end else if (!m_pend) begin
      if (ce_in) begin
        d = need_of(mode_in, int'(cmd_in));
        if (d[2]) e_cerr = 1;
        else begin
          m_pend = 1; m_need = d[1:0]; m_mode = mode_in;
          m_cin = cin_in; m_cmd = cmd_in; m_have = iv_in;
          if (iv_in[0]) m_opa = opa_in;
          if (iv_in[1]) m_opb = opb_in;
          m_wait = 0;
          fire = ((m_have & m_need) == m_need);
        end
      end
    end else begin
      if (ce_in) begin
        m_have |= iv_in;
        if (iv_in[0]) m_opa = opa_in;
        if (iv_in[1]) m_opb = opb_in;
      end
      fire = ((m_have & m_need) == m_need);
      if (!fire) begin
        m_wait++;
`ifdef ALU_COLLECTOR_TIMEOUT_EN
        if (m_wait == 16) begin m_pend = 0; e_to = 1; end
`endif
      end
    end
    if (fire) begin
      e_ce = 1; e_mode = m_mode; e_cin = m_cin; e_cmd = m_cmd;
      e_iv = m_need;
      e_opa = m_need[0] ? m_opa : 8'h00;
      e_opb = m_need[1] ? m_opb : 8'h00;
      m_pend = 0; m_iss = 1;
    end
    e_busy = m_pend | m_iss;
    e_rdy = !m_iss;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    step();
    step();
    checks++;
    if ({CE, busy, cmd_err, timeout_err, INP_VALID, OPA, OPB,
         CMD, MODE, CIN, in_ready} !== 28'h1) begin
      errors++;
      $display("FAIL reset_state: got CE=%b busy=%b cerr=%b to=%b iv=%b a=%h b=%h cmd=%h rdy=%b, want all 0 rdy=1",
               CE, busy, cmd_err, timeout_err, INP_VALID, OPA, OPB, CMD, in_ready);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_both();
    drive(1, 1, 0, 4'd0, 2'b11, 8'h12, 8'h34);
    step();
    set_idle();
    checks++;
    if ({CE, INP_VALID, OPA, OPB, in_ready, busy} !==
        {1'b1, 2'b11, 8'h12, 8'h34, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL both_issue: got CE=%b iv=%b a=%h b=%h rdy=%b busy=%b, want 1 11 12 34 0 1",
               CE, INP_VALID, OPA, OPB, in_ready, busy);
    end
    step();
    checks++;
    if ({CE, OPA, OPB, in_ready, busy} !==
        {1'b0, 8'h12, 8'h34, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL both_hold: got CE=%b a=%h b=%h rdy=%b busy=%b, want 0 12 34 1 0",
               CE, OPA, OPB, in_ready, busy);
    end
  endtask

  task automatic test_split();
    drive(1, 0, 0, 4'd1, 2'b01, 8'hF0, 8'h99);
    step();
    set_idle();
    checks++;
    if ({CE, busy, in_ready} !== 3'b011) begin
      errors++;
      $display("FAIL split_wait: got CE=%b busy=%b rdy=%b, want 0 1 1",
               CE, busy, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({CE, busy} !== 2'b01) begin
        errors++;
        $display("FAIL split_idle%0d: got CE=%b busy=%b, want 0 1",
                 i, CE, busy);
      end
    end
    // MODE/CMD/OPA offered here must be ignored while waiting
    drive(1, 1, 1, 4'd9, 2'b10, 8'h55, 8'h0F);
    step();
    set_idle();
    checks++;
    if ({CE, INP_VALID, CMD, MODE, CIN, OPA, OPB} !==
        {1'b1, 2'b11, 4'd1, 1'b0, 1'b0, 8'hF0, 8'h0F}) begin
      errors++;
      $display("FAIL split_issue: got CE=%b iv=%b cmd=%0d mode=%b cin=%b a=%h b=%h, want 1 11 1 0 0 f0 0f",
               CE, INP_VALID, CMD, MODE, CIN, OPA, OPB);
    end
    step();
  endtask

  task automatic test_b_only();
    drive(1, 1, 1, 4'd6, 2'b11, 8'hAA, 8'h05);
    step();
    set_idle();
    checks++;
    if ({CE, INP_VALID, OPA, OPB, CMD, CIN} !==
        {1'b1, 2'b10, 8'h00, 8'h05, 4'd6, 1'b1}) begin
      errors++;
      $display("FAIL b_only: got CE=%b iv=%b a=%h b=%h cmd=%0d cin=%b, want 1 10 00 05 6 1",
               CE, INP_VALID, OPA, OPB, CMD, CIN);
    end
    step();
  endtask

  task automatic test_illegal();
    drive(1, 0, 0, 4'd14, 2'b11, 8'h01, 8'h02);
    step();
    set_idle();
    checks++;
    if ({cmd_err, CE, busy, in_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL illegal_m0: got cerr=%b CE=%b busy=%b rdy=%b, want 1 0 0 1",
               cmd_err, CE, busy, in_ready);
    end
    step();
    checks++;
    if ({cmd_err, CE} !== 2'b00) begin
      errors++;
      $display("FAIL illegal_pulse: got cerr=%b CE=%b, want 0 0",
               cmd_err, CE);
    end
    drive(1, 1, 0, 4'd11, 2'b11, 8'h01, 8'h02);
    step();
    set_idle();
    checks++;
    if ({cmd_err, CE, busy} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_m1: got cerr=%b CE=%b busy=%b, want 1 0 0",
               cmd_err, CE, busy);
    end
    step();
  endtask

  task automatic test_reset_wait();
    drive(1, 0, 1, 4'd3, 2'b01, 8'h5A, 8'h00);
    step();
    set_idle();
    rst = 1'b0;
    drive(1, 0, 0, 4'd0, 2'b10, 8'h00, 8'hC3);
    step();
    set_idle();
    checks++;
    if ({CE, in_ready, busy, cmd_err, OPA, OPB} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_wait: got CE=%b rdy=%b busy=%b cerr=%b a=%h b=%h, want 0 1 0 0 00 00",
               CE, in_ready, busy, cmd_err, OPA, OPB);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({CE, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_after: got CE=%b busy=%b rdy=%b, want 0 0 1",
               CE, busy, in_ready);
    end
    rst = 1'b0;
    drive(1, 1, 0, 4'd0, 2'b11, 8'h11, 8'h22);
    step();
    rst = 1'b1;
    set_idle();
    checks++;
    if ({CE, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_issue: got CE=%b busy=%b, want 0 0", CE, busy);
    end
    step();
  endtask

  task automatic test_timeout();
    bit exp_to, exp_busy;
    drive(1, 1, 0, 4'd2, 2'b01, 8'h3C, 8'h00);
    step();
    set_idle();
    for (int i = 1; i <= 20; i++) begin
      step();
`ifdef ALU_COLLECTOR_TIMEOUT_EN
      exp_to = (i == 16);
      exp_busy = (i < 16);
`else
      exp_to = 0;
      exp_busy = 1;
`endif
      checks++;
      if ({CE, timeout_err, busy} !== {1'b0, exp_to, exp_busy}) begin
        errors++;
        $display("FAIL timeout_c%0d: got CE=%b to=%b busy=%b, want 0 %b %b",
                 i, CE, timeout_err, busy, exp_to, exp_busy);
      end
    end
    drive(1, 1, 0, 4'd6, 2'b10, 8'h00, 8'h77);
    step();
    set_idle();
    checks++;
`ifdef ALU_COLLECTOR_TIMEOUT_EN
    if ({CE, CMD, INP_VALID, OPA, OPB} !==
        {1'b1, 4'd6, 2'b10, 8'h00, 8'h77}) begin
`else
    if ({CE, CMD, INP_VALID, OPA, OPB} !==
        {1'b1, 4'd2, 2'b11, 8'h3C, 8'h77}) begin
`endif
      errors++;
      $display("FAIL timeout_next: got CE=%b cmd=%0d iv=%b a=%h b=%h",
               CE, CMD, INP_VALID, OPA, OPB);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 4'd1, 2'b11, 8'h11, 8'h22);
    step();
    drive(1, 0, 1, 4'd13, 2'b11, 8'h33, 8'h44);
    step();
    checks++;
    if ({CE, busy, in_ready, OPA} !== {1'b0, 1'b0, 1'b1, 8'h11}) begin
      errors++;
      $display("FAIL b2b_ignored: got CE=%b busy=%b rdy=%b a=%h, want 0 0 1 11",
               CE, busy, in_ready, OPA);
    end
    step();
    set_idle();
    checks++;
    if ({CE, CMD, MODE, CIN, OPA, OPB} !==
        {1'b1, 4'd13, 1'b0, 1'b1, 8'h33, 8'h44}) begin
      errors++;
      $display("FAIL b2b_second: got CE=%b cmd=%0d mode=%b cin=%b a=%h b=%h, want 1 13 0 1 33 44",
               CE, CMD, MODE, CIN, OPA, OPB);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
            4'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
      step();
      checks++;
      if ({CE, MODE, CIN, CMD, INP_VALID, OPA, OPB,
           busy, in_ready, timeout_err, cmd_err} !==
          {e_ce, e_mode, e_cin, e_cmd, e_iv, e_opa, e_opb,
           e_busy, e_rdy, e_to, e_cerr}) begin
        errors++;
        $display("FAIL random_%0d: got ce=%b m=%b ci=%b cmd=%h iv=%b a=%h b=%h busy=%b rdy=%b to=%b ce=%b want %b %b %b %h %b %h %h %b %b %b %b",
                 i, CE, MODE, CIN, CMD, INP_VALID, OPA, OPB,
                 busy, in_ready, timeout_err, cmd_err,
                 e_ce, e_mode, e_cin, e_cmd, e_iv, e_opa, e_opb,
                 e_busy, e_rdy, e_to, e_cerr);
      end
    end
    rst = 1'b1;
    set_idle();
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    test_reset();
    test_both();
    test_split();
    test_b_only();
    test_illegal();
    test_reset_wait();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_operand_collector.md
ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width.
REQ-002 SHALL have parameter CMD_WIDTH, default 4, meaning command width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have inputs CE_in (1), MODE_in (1), CIN_in (1), CMD_in (CMD_WIDTH), INP_VALID_in (2), OPA_in (WIDTH), OPB_in (WIDTH): producer-side request and operands.
REQ-006 SHALL have output in_ready, 1: producer inputs are sampled only when in_ready=1.
REQ-007 SHALL have outputs CE, MODE, CIN (1 each), CMD (CMD_WIDTH), INP_VALID (2), OPA, OPB (WIDTH): registered ALU-side request.
REQ-008 SHALL have outputs busy (1), timeout_err (1), cmd_err (1).

Function
REQ-009 SHALL decode the required operand set from MODE/CMD: MODE=1: CMD 0-3, 8-10 both; 4,5 A-only; 6,7 B-only. MODE=0: CMD 0-5, 12, 13 both; 6,8,9 A-only; 7,10,11 B-only. Every other code is illegal.
REQ-010 SHALL implement FSM states IDLE, WAIT, ISSUE; in_ready=1 in IDLE and WAIT, 0 in ISSUE.
REQ-011 IDLE, CE_in=1, legal CMD: latch MODE/CMD/CIN and each operand whose INP_VALID_in bit is set; go ISSUE if required set complete, else WAIT with counter=0.
REQ-012 IDLE, CE_in=1, illegal CMD: pulse cmd_err for one cycle; remain in IDLE; no issue.
REQ-013 WAIT: CE_in=1 merges newly valid operands only; MODE_in/CMD_in/CIN_in ignored; a repeated operand overwrites the held value.
REQ-014 WAIT: counter increments every cycle; required set complete -> ISSUE next cycle.
REQ-015 ISSUE: CE=1 for exactly one cycle; INP_VALID equals the required pattern (01 A-only, 10 B-only, 11 both); unused operand driven 0; then IDLE.
REQ-016 Latency: the cycle in which the operand set completes is N; CE=1 in cycle N+1.
REQ-017 Outside ISSUE, CE=0 and MODE/CMD/CIN/INP_VALID/OPA/OPB hold their last values, never X.
REQ-018 Completion and timeout in the same cycle: completion wins.
REQ-019 busy=1 in WAIT and ISSUE.

Reset
REQ-020 rst=0 at posedge: state IDLE, counter 0, all outputs 0 except in_ready=1, held operands cleared.
REQ-021 Reset mid-WAIT or mid-ISSUE SHALL abort the request with no CE pulse and no error pulse.

Configuration
REQ-022 Macro ALU_COLLECTOR_TIMEOUT_EN defined: when counter reaches 16 in WAIT without completion, pulse timeout_err for one cycle, discard the request, return to IDLE.
REQ-023 Macro undefined: WAIT lasts indefinitely until completion or reset; timeout_err is tied 0; the counter is not implemented.

Structure
REQ-024 Package alu_collector_pkg SHALL hold the state enum, the required-operand enum (NONE, A_ONLY, B_ONLY, BOTH), TIMEOUT_CYCLES=16, and the command-code constants.
REQ-025 Combinational sub-module alu_operand_decode SHALL map MODE/CMD to the required-operand enum plus an illegal flag.

Verification
REQ-026 MODE=1, CMD=0, INP_VALID_in=11, OPA=8'h12, OPB=8'h34 in IDLE -> next cycle CE=1, INP_VALID=11, OPA=12, OPB=34.
REQ-027 MODE=0, CMD=1, INP_VALID_in=01 with OPA=8'hF0, then 5 idle cycles, then INP_VALID_in=10 with OPB=8'h0F -> CE=1 one cycle later, INP_VALID=11, CMD=1 held.
REQ-028 MODE=1, CMD=6, INP_VALID_in=11, OPA=8'hAA, OPB=8'h05 -> CE=1, INP_VALID=10, OPA=0, OPB=05.
REQ-029 With ALU_COLLECTOR_TIMEOUT_EN: MODE=1, CMD=2, only A supplied -> timeout_err pulses 16 cycles later, CE never asserted, state returns to IDLE.
REQ-030 MODE=0, CMD=14 -> cmd_err pulses once, CE stays 0; rst=0 during WAIT -> no CE, in_ready=1 the following cycle.
